// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared types and 74LS181 function codes for the nibble-serial ALU sequencer.
// Optional zero flag is enabled by defining NSALU_ZERO_EN.
package nibble_serial_alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Active-high data conventions; S_XOR is S_SUB's code used with m=1.
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/nibble_serial_alu_ctrl_if.sv
// Request/response bus between a requester and the nibble-serial ALU sequencer.
interface nibble_serial_alu_ctrl_if #(parameter int WIDTH = 16);

    logic             start;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [3:0]       s;
    logic             m;
    logic             cin_;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout_;
    logic             aeqb_all;
    logic             zero;

    modport master (
        output start, opa, opb, s, m, cin_,
        input  busy, done, result, cout_, aeqb_all, zero
    );

    modport slave (
        input  start, opa, opb, s, m, cin_,
        output busy, done, result, cout_, aeqb_all, zero
    );

endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequences WIDTH-bit operations through one external 74LS181, one nibble per clock.
// Define NSALU_ZERO_EN to build the registered result==0 flag.
module nibble_serial_alu_ctrl
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    nibble_serial_alu_ctrl_if.slave bus,
    output logic [3:0]              alu_a,
    output logic [3:0]              alu_b,
    output logic [3:0]              alu_s,
    output logic                    alu_m,
    output logic                    alu_cn_,
    input  logic [3:0]              alu_f,
    input  logic                    alu_cn4_,
    input  logic                    alu_aeqb
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa_r, opb_r, acc, result_r;
    logic [3:0]       s_r;
    logic             m_r, cin_r, carry_r, eq_acc;
    logic             done_r, cout_r, aeqb_r;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last = (cnt == CW'(NIB - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are published on the edge leaving DONE so done and the flags appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_r    <= '0;
            opb_r    <= '0;
            acc      <= '0;
            result_r <= '0;
            s_r      <= 4'b0000;
            m_r      <= 1'b1;
            cin_r    <= 1'b1;
            carry_r  <= 1'b1;
            eq_acc   <= 1'b0;
            cnt      <= '0;
            done_r   <= 1'b0;
            cout_r   <= 1'b1;
            aeqb_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa_r  <= bus.opa;
                        opb_r  <= bus.opb;
                        s_r    <= bus.s;
                        m_r    <= bus.m;
                        cin_r  <= bus.cin_;
                        cnt    <= '0;
                        eq_acc <= 1'b1;
                    end
                end
                RUN: begin
                    acc[{cnt, 2'b00} +: 4] <= alu_f;
                    carry_r <= alu_cn4_;
                    eq_acc  <= eq_acc & alu_aeqb;
                    if (!last) cnt <= cnt + 1'b1;
                end
                DONE: begin
                    done_r   <= 1'b1;
                    result_r <= acc;
                    cout_r   <= carry_r;
                    aeqb_r   <= eq_acc;
                end
                default: ;
            endcase
        end
    end

    assign alu_a   = opa_r[{cnt, 2'b00} +: 4];
    assign alu_b   = opb_r[{cnt, 2'b00} +: 4];
    assign alu_s   = s_r;
    assign alu_m   = m_r;
    assign alu_cn_ = (cnt == '0) ? cin_r : carry_r;

    assign bus.busy     = (state == RUN) || (state == DONE);
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.cout_    = cout_r;
    assign bus.aeqb_all = aeqb_r;

`ifdef NSALU_ZERO_EN
    logic zero_r;

    always_ff @(posedge clk) begin
        if (rst)                zero_r <= 1'b0;
        else if (state == DONE) zero_r <= (acc == '0);
    end

    assign bus.zero = zero_r;
`else
    assign bus.zero = 1'b0;
`endif

endmodule
